// File: rtl/data_mem_arbiter_pkg.sv
// dm_arb_pkg: shared FSM encodings and default sizing for the data memory arbiter
package dm_arb_pkg;
  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;
  localparam int MAX_WAIT_DEF = 4;
  localparam int WAIT_W_DEF = 3;
  localparam int STAT_W_DEF = 16;
endpackage

// File: rtl/arb_wait_counter.sv
// arb_wait_counter: clearable counter with a compare-to-limit flag; callers gate inc with at_max to saturate
module arb_wait_counter #(
  parameter int W = 3,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);
  assign at_max = cnt == MAX;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data memory port between the CPU MEM stage and a DMA master
module data_mem_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int WAIT_W = WAIT_W_DEF,
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ack,
  output logic [31:0]       dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [STAT_W-1:0] stall_count
);
  state_t state, state_nx;
  logic cpu_req, idle, starve, dma_grant, wait_sat, stall_sat;
  logic [WAIT_W-1:0] wait_cnt;
  assign cpu_req = cpu_mem_read | cpu_mem_write;
  assign dma_ack = state == S_ACK;
  assign starve = wait_cnt == WAIT_W'(MAX_WAIT);
  // reset_n folds into the grant so strobes and stall stay low throughout reset
  always_comb begin
    idle = state == S_IDLE;
    dma_grant = reset_n & idle & dma_req & (~cpu_req | starve);
    state_nx = dma_grant ? S_ACK : S_IDLE;
    mem_read = reset_n & (dma_grant ? ~dma_we : cpu_mem_read);
    mem_write = reset_n & (dma_grant ? dma_we : cpu_mem_write);
    mem_addr = dma_grant ? dma_addr : cpu_addr;
    mem_wdata = dma_grant ? dma_wdata : cpu_wdata;
    cpu_rdata = (!dma_grant && cpu_mem_read) ? mem_rdata : '0;
    cpu_stall = dma_grant & cpu_req;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      dma_rdata <= '0;
    end else begin
      state <= state_nx;
      if (dma_grant && !dma_we) dma_rdata <= mem_rdata;
    end
  arb_wait_counter #(.W(WAIT_W), .MAX(WAIT_W'(MAX_WAIT))) u_wait (
    .clk(clk), .reset_n(reset_n),
    .clr(dma_grant | ~dma_req), .inc(idle & dma_req & ~wait_sat),
    .cnt(wait_cnt), .at_max(wait_sat)
  );
  arb_wait_counter #(.W(STAT_W), .MAX('1)) u_stall (
    .clk(clk), .reset_n(reset_n),
    .clr(1'b0), .inc(cpu_stall & ~stall_sat),
    .cnt(stall_count), .at_max(stall_sat)
  );
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: vector table plus DMA read-data scoreboard for data_mem_arbiter
module tb_data_mem_arbiter;
  logic clk = 1'b0, reset_n;
  logic cpu_mem_read, cpu_mem_write, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic cpu_stall, dma_ack, mem_read, mem_write;
  logic [15:0] stall_count;
  int n_chk = 0, n_fail = 0;
  logic [31:0] sb[$];
  logic [31:0] model_rd;

  data_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd, mrd;
    logic emr, emw; logic [31:0] ea, ed, ecrd;
    logic estall, egnt;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic cr, cw, input logic [31:0] ca, cd,
                        input logic dr, dw, input logic [31:0] da, dd, mrd);
    cpu_mem_read = cr; cpu_mem_write = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; mem_rdata = mrd;
  endtask

  task automatic push_grant(input logic we, input logic [31:0] rd);
    if (!we) model_rd = rd;
    sb.push_back(model_rd);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (reset_n === 1'b1 && dma_ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dma_ack_unexpected: got ack=1 expected no outstanding grant at %0t", $time);
      end else chk("dma_rdata_at_ack", dma_rdata, sb.pop_front());
    end

  initial begin
    v[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEADBEEF,
             1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    v[1] = '{1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h11111111,
             1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0};
    v[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0,
             1'b0, 1'b1, 32'h40, 32'h12345678, 32'h0, 1'b0, 1'b1};
    v[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D,
             1'b1, 1'b0, 32'h80, 32'h0, 32'h0, 1'b0, 1'b1};
    v[4] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h40, 32'h55, 32'h77777777,
             1'b1, 1'b0, 32'h10, 32'h0, 32'h77777777, 1'b0, 1'b0};
    v[5] = '{1'b1, 1'b1, 32'h30, 32'h99, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2468ACE0,
             1'b1, 1'b1, 32'h30, 32'h99, 32'h2468ACE0, 1'b0, 1'b0};
    v[6] = '{1'b0, 1'b0, 32'h34, 32'h66, 1'b0, 1'b0, 32'h0, 32'h0, 32'h13579BDF,
             1'b0, 1'b0, 32'h34, 32'h66, 32'h0, 1'b0, 1'b0};
    model_rd = '0;
    reset_n = 1'b0;
    set_in(1'b0, 1'b1, 32'h8, 32'h1, 1'b1, 1'b1, 32'h40, 32'h2, 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
    chk("rst_stall_count", stall_count, 0);
    step;
    reset_n = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step;
    for (int i = 0; i < 7; i++) begin
      set_in(v[i].cr, v[i].cw, v[i].ca, v[i].cd, v[i].dr, v[i].dw, v[i].da, v[i].dd, v[i].mrd);
      if (v[i].egnt) push_grant(v[i].dw, v[i].mrd);
      @(negedge clk);
      chk($sformatf("v%0d_mem_read", i), mem_read, v[i].emr);
      chk($sformatf("v%0d_mem_write", i), mem_write, v[i].emw);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v[i].ea);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v[i].ed);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, v[i].ecrd);
      chk($sformatf("v%0d_cpu_stall", i), cpu_stall, v[i].estall);
      chk($sformatf("v%0d_ack_idle", i), dma_ack, 0);
      step;
      set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_ack_next", i), dma_ack, v[i].egnt);
      step;
    end
    chk("table_stall_count", stall_count, 0);
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0) push_grant(1'b1, 32'h0);
      @(negedge clk);
      chk($sformatf("b2b_c%0d_mem_write", c), mem_write, c % 2 == 0);
      chk($sformatf("b2b_c%0d_ack", c), dma_ack, c % 2 == 1);
      step;
    end
    dma_req = 1'b0;
    @(negedge clk);
    chk("b2b_ack_end", dma_ack, 0);
    step;
    set_in(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      mem_rdata = 32'h1000 + c;
      if (c == 4) push_grant(1'b0, mem_rdata);
      @(negedge clk);
      chk($sformatf("cont_c%0d_stall", c), cpu_stall, c == 4);
      chk($sformatf("cont_c%0d_addr", c), mem_addr, c == 4 ? 32'h80 : 32'h10);
      chk($sformatf("cont_c%0d_ack", c), dma_ack, c == 5);
      chk($sformatf("cont_c%0d_stall_count", c), stall_count, c == 5 ? 1 : 0);
      step;
    end
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D);
    push_grant(1'b0, 32'hCAFEF00D);
    @(negedge clk);
    chk("rd_mem_read", mem_read, 1);
    chk("rd_mem_addr", mem_addr, 32'h80);
    step;
    dma_req = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rd_ack", dma_ack, 1);
    step;
    @(negedge clk);
    chk("rd_hold", dma_rdata, 32'hCAFEF00D);
    step;
    set_in(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h44, 32'h77, 32'h0);
    push_grant(1'b1, 32'h0);
    step;
    set_in(1'b0, 1'b1, 32'h8, 32'h5, 1'b1, 1'b1, 32'h44, 32'h77, 32'h0);
    @(negedge clk);
    chk("sack_ack", dma_ack, 1);
    chk("sack_cpu_write", mem_write, 1);
    chk("sack_addr", mem_addr, 32'h8);
    chk("sack_stall", cpu_stall, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ack", dma_ack, 0);
    chk("arst_mem_write", mem_write, 0);
    chk("arst_dma_rdata", dma_rdata, 0);
    chk("arst_stall_count", stall_count, 0);
    model_rd = '0;
    step;
    reset_n = 1'b1;
    cpu_mem_write = 1'b0;
    push_grant(1'b1, 32'h0);
    @(negedge clk);
    chk("post_rst_grant", mem_write, 1);
    chk("post_rst_addr", mem_addr, 32'h44);
    step;
    dma_req = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", dma_ack, 1);
    step;
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
